// File: rtl/nasti_master_pkg.sv
// Shared types and constants for the single-outstanding NASTI burst master.
package nasti_master_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AW   = 3'd1,
    W    = 3'd2,
    B    = 3'd3,
    AR   = 3'd4,
    R    = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/nasti_burst_master_if.sv
// Full NASTI channel set (AW/W/B/AR/R) with master and slave views.
interface nasti_channel #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int USER_WIDTH = 1
) ();

  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_qos;
  logic [3:0]              aw_region;
  logic [USER_WIDTH-1:0]   aw_user;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [USER_WIDTH-1:0]   w_user;
  logic                    w_valid;
  logic                    w_ready;

  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;
  logic                    b_valid;
  logic                    b_ready;

  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_qos;
  logic [3:0]              ar_region;
  logic [USER_WIDTH-1:0]   ar_user;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/nasti_burst_master.sv
// Command-driven NASTI burst master: one read or write burst in flight at a time,
// with a single completion carrying the worst response and a protocol-error flag.
module nasti_burst_master
  import nasti_master_pkg::*;
#(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rstn,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,

  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [DATA_WIDTH-1:0] wd_data,

  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_err,

  nasti_channel.master          nasti
);

  state_t                state_reg, state_next;
  logic [ID_WIDTH-1:0]   id_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [7:0]            len_reg;
  logic [2:0]            size_reg;
  logic [7:0]            beat_reg;
  logic [1:0]            resp_reg;
  logic                  err_reg;

  logic cmd_hs, w_hs, b_hs, r_hs, last_beat;

  assign cmd_hs    = (state_reg == IDLE) && cmd_valid;
  assign w_hs      = (state_reg == W) && wd_valid && nasti.w_ready;
  assign b_hs      = (state_reg == B) && nasti.b_valid;
  assign r_hs      = (state_reg == R) && nasti.r_valid && rd_ready;
  assign last_beat = (beat_reg == len_reg);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (cmd_valid)             state_next = cmd_write ? AW : AR;
      AW:   if (nasti.aw_ready)        state_next = W;
      W:    if (w_hs && last_beat)     state_next = B;
      B:    if (nasti.b_valid)         state_next = DONE;
      AR:   if (nasti.ar_ready)        state_next = R;
      // The burst ends on beat len even if the slave's r_last disagrees.
      R:    if (r_hs && last_beat)     state_next = DONE;
      DONE: if (rsp_ready)             state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      id_reg   <= '0;
      addr_reg <= '0;
      len_reg  <= '0;
      size_reg <= '0;
      beat_reg <= '0;
      resp_reg <= OKAY;
      err_reg  <= 1'b0;
    end else begin
      if (cmd_hs) begin
        id_reg   <= cmd_id;
        addr_reg <= cmd_addr;
        len_reg  <= cmd_len;
        size_reg <= cmd_size;
        beat_reg <= '0;
        resp_reg <= OKAY;
        err_reg  <= 1'b0;
      end
      if (w_hs) begin
        beat_reg <= beat_reg + 8'd1;
      end
      if (b_hs) begin
        resp_reg <= nasti.b_resp;
        if (nasti.b_id != id_reg) err_reg <= 1'b1;
      end
      if (r_hs) begin
        beat_reg <= beat_reg + 8'd1;
        if (nasti.r_resp > resp_reg) resp_reg <= nasti.r_resp;
        if ((nasti.r_id != id_reg) || (nasti.r_last != last_beat)) err_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    cmd_ready       = (state_reg == IDLE);

    nasti.aw_valid  = (state_reg == AW);
    nasti.aw_id     = id_reg;
    nasti.aw_addr   = addr_reg;
    nasti.aw_len    = len_reg;
    nasti.aw_size   = size_reg;
    nasti.aw_burst  = BURST_INCR;
    nasti.aw_lock   = 1'b0;
    nasti.aw_cache  = 4'd0;
    nasti.aw_prot   = 3'd0;
    nasti.aw_qos    = 4'd0;
    nasti.aw_region = 4'd0;
    nasti.aw_user   = {USER_WIDTH{1'b0}};

    nasti.w_valid   = (state_reg == W) && wd_valid;
    nasti.w_data    = wd_data;
    nasti.w_strb    = '1;
    nasti.w_last    = last_beat;
    nasti.w_user    = {USER_WIDTH{1'b0}};
    wd_ready        = (state_reg == W) && nasti.w_ready;

    nasti.b_ready   = (state_reg == B);

    nasti.ar_valid  = (state_reg == AR);
    nasti.ar_id     = id_reg;
    nasti.ar_addr   = addr_reg;
    nasti.ar_len    = len_reg;
    nasti.ar_size   = size_reg;
    nasti.ar_burst  = BURST_INCR;
    nasti.ar_lock   = 1'b0;
    nasti.ar_cache  = 4'd0;
    nasti.ar_prot   = 3'd0;
    nasti.ar_qos    = 4'd0;
    nasti.ar_region = 4'd0;
    nasti.ar_user   = {USER_WIDTH{1'b0}};

    nasti.r_ready   = (state_reg == R) && rd_ready;
    rd_valid        = (state_reg == R) && nasti.r_valid;
    rd_data         = nasti.r_data;
    rd_last         = nasti.r_last;

    rsp_valid       = (state_reg == DONE);
    rsp_resp        = resp_reg;
    rsp_err         = err_reg;
  end

endmodule

// File: tb/tb_nasti_burst_master.sv
// Scoreboard bench for nasti_burst_master against a behavioural RAM slave.
module tb_nasti_burst_master;

  localparam int IDW = 1;
  localparam int AW_W = 16;
  localparam int DW = 128;
  localparam int UW = 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic            cmd_valid, cmd_ready, cmd_write;
  logic [IDW-1:0]  cmd_id;
  logic [AW_W-1:0] cmd_addr;
  logic [7:0]      cmd_len;
  logic [2:0]      cmd_size;
  logic            wd_valid, wd_ready;
  logic [DW-1:0]   wd_data;
  logic            rd_valid, rd_ready, rd_last;
  logic [DW-1:0]   rd_data;
  logic            rsp_valid, rsp_ready, rsp_err;
  logic [1:0]      rsp_resp;

  nasti_channel #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW_W), .DATA_WIDTH(DW), .USER_WIDTH(UW)) nasti_bus ();

  nasti_burst_master #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW_W), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_id(cmd_id),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp), .rsp_err(rsp_err),
    .nasti(nasti_bus)
  );

  typedef struct { logic [IDW-1:0] id; logic [AW_W-1:0] addr; logic [7:0] len; logic [2:0] size; } ax_t;
  typedef struct { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct { logic [1:0] resp; logic err; } rsp_t;

  ax_t   exp_aw[$], exp_ar[$];
  beat_t exp_w[$], exp_rd[$];
  rsp_t  exp_rsp[$];

  int n_vec = 0;
  int n_miss = 0;

  // Slave behaviour knobs, set by the stimulus between transactions.
  int aw_stall = 0;
  int r_err_cfg = -1;
  int r_last_cfg = -1;

  logic [DW-1:0] mem [0:255];

  function automatic logic [DW-1:0] dword(input int i);
    return {4{32'hD0C0_0000 + 32'(i)}};
  endfunction

  function automatic int widx(input logic [AW_W-1:0] a, input int beat);
    return ((int'(a) >> 4) + beat) & 255;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expired(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Monitor: compares every DUT-presented beat against the scoreboard queues.
  initial begin
    beat_t b;
    rsp_t  r;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (nasti_bus.aw_valid) begin
          chk("no_w_before_aw", DW'(nasti_bus.w_valid), DW'(0));
          if (exp_aw.size() == 0) expired("unexpected_aw");
          else begin
            chk("aw_addr", DW'(nasti_bus.aw_addr), DW'(exp_aw[0].addr));
            chk("aw_id", DW'(nasti_bus.aw_id), DW'(exp_aw[0].id));
            chk("aw_len", DW'(nasti_bus.aw_len), DW'(exp_aw[0].len));
            chk("aw_size_burst", DW'({nasti_bus.aw_size, nasti_bus.aw_burst}), DW'({exp_aw[0].size, 2'b01}));
            if (nasti_bus.aw_ready) void'(exp_aw.pop_front());
          end
        end
        if (nasti_bus.ar_valid) begin
          if (exp_ar.size() == 0) expired("unexpected_ar");
          else begin
            chk("ar_addr", DW'(nasti_bus.ar_addr), DW'(exp_ar[0].addr));
            chk("ar_id_len", DW'({nasti_bus.ar_id, nasti_bus.ar_len}), DW'({exp_ar[0].id, exp_ar[0].len}));
            chk("ar_size_burst", DW'({nasti_bus.ar_size, nasti_bus.ar_burst}), DW'({exp_ar[0].size, 2'b01}));
            if (nasti_bus.ar_ready) void'(exp_ar.pop_front());
          end
        end
        if (nasti_bus.w_valid && nasti_bus.w_ready) begin
          if (exp_w.size() == 0) expired("unexpected_w");
          else begin
            b = exp_w.pop_front();
            chk("w_data", nasti_bus.w_data, b.data);
            chk("w_last", DW'(nasti_bus.w_last), DW'(b.last));
            chk("w_strb", DW'(nasti_bus.w_strb), DW'(16'hFFFF));
          end
        end
        if (rd_valid && rd_ready) begin
          if (exp_rd.size() == 0) expired("unexpected_rd");
          else begin
            b = exp_rd.pop_front();
            chk("rd_data", rd_data, b.data);
            chk("rd_last", DW'(rd_last), DW'(b.last));
          end
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_rsp.size() == 0) expired("unexpected_rsp");
          else begin
            r = exp_rsp.pop_front();
            chk("rsp_resp", DW'(rsp_resp), DW'(r.resp));
            chk("rsp_err", DW'(rsp_err), DW'(r.err));
          end
        end
      end
    end
  end

  // Behavioural slave with RAM, optional AW stall and read-response corruption.
  initial begin
    int aw_cnt, s_wbeat, r_beat, s_rlen, last_at;
    logic [AW_W-1:0] s_waddr, s_raddr;
    logic [IDW-1:0] s_wid, s_rid;
    bit b_pend, r_act, new_ar, bhs, rhs;
    aw_cnt = 0; s_wbeat = 0; r_beat = 0; s_rlen = 0;
    s_waddr = '0; s_raddr = '0; s_wid = '0; s_rid = '0;
    b_pend = 0; r_act = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    nasti_bus.aw_ready = 1'b0; nasti_bus.w_ready = 1'b0; nasti_bus.ar_ready = 1'b0;
    nasti_bus.b_valid = 1'b0; nasti_bus.b_id = '0; nasti_bus.b_resp = 2'b00; nasti_bus.b_user = '0;
    nasti_bus.r_valid = 1'b0; nasti_bus.r_id = '0; nasti_bus.r_data = '0;
    nasti_bus.r_resp = 2'b00; nasti_bus.r_last = 1'b0; nasti_bus.r_user = '0;
    forever begin
      @(negedge clk);
      new_ar = 0; bhs = 0; rhs = 0;
      if (!rstn) begin
        aw_cnt = 0; s_wbeat = 0; b_pend = 0; r_act = 0;
      end else begin
        if (nasti_bus.aw_valid) begin
          if (nasti_bus.aw_ready) begin
            s_waddr = nasti_bus.aw_addr; s_wid = nasti_bus.aw_id; s_wbeat = 0; aw_cnt = 0;
          end else aw_cnt++;
        end
        if (nasti_bus.w_valid && nasti_bus.w_ready) begin
          mem[widx(s_waddr, s_wbeat)] = nasti_bus.w_data;
          s_wbeat++;
          if (nasti_bus.w_last) b_pend = 1;
        end
        bhs = nasti_bus.b_valid && nasti_bus.b_ready;
        if (nasti_bus.ar_valid && nasti_bus.ar_ready) begin
          s_raddr = nasti_bus.ar_addr; s_rlen = int'(nasti_bus.ar_len); s_rid = nasti_bus.ar_id; new_ar = 1;
        end
        rhs = nasti_bus.r_valid && nasti_bus.r_ready;
      end
      @(posedge clk);
      #1;
      if (!rstn) begin
        nasti_bus.aw_ready = 1'b0; nasti_bus.w_ready = 1'b0; nasti_bus.ar_ready = 1'b0;
        nasti_bus.b_valid = 1'b0; nasti_bus.r_valid = 1'b0;
        b_pend = 0; r_act = 0; aw_cnt = 0;
      end else begin
        nasti_bus.aw_ready = (aw_cnt >= aw_stall);
        nasti_bus.ar_ready = 1'b1;
        nasti_bus.w_ready = 1'b1;
        if (bhs) nasti_bus.b_valid = 1'b0;
        if (b_pend) begin
          nasti_bus.b_valid = 1'b1; nasti_bus.b_id = s_wid; nasti_bus.b_resp = 2'b00; b_pend = 0;
        end
        if (rhs) begin
          r_beat++;
          if (r_beat > s_rlen) r_act = 0;
        end
        if (new_ar) begin
          r_act = 1; r_beat = 0;
        end
        nasti_bus.r_valid = r_act;
        if (r_act) begin
          last_at = (r_last_cfg < 0) ? s_rlen : r_last_cfg;
          nasti_bus.r_data = mem[widx(s_raddr, r_beat)];
          nasti_bus.r_id = s_rid;
          nasti_bus.r_last = (r_beat == last_at);
          nasti_bus.r_resp = (r_beat == r_err_cfg) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  task automatic send_cmd(input logic wr, input logic [IDW-1:0] id, input logic [AW_W-1:0] addr, input logic [7:0] len);
    bit ok = 0;
    @(posedge clk);
    #1;
    cmd_write = wr; cmd_id = id; cmd_addr = addr; cmd_len = len; cmd_size = 3'd4; cmd_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) expired("cmd_accept");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input int n, input int base);
    bit ok;
    for (int i = 0; i < n; i++) begin
      wd_data = dword(base + i);
      wd_valid = 1'b1;
      ok = 0;
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (wd_ready) begin ok = 1; break; end
      end
      if (!ok) expired("wd_accept");
      @(posedge clk);
      #1;
    end
    wd_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (exp_rsp.size() == 0 && exp_rd.size() == 0 && exp_w.size() == 0) begin ok = 1; break; end
    end
    if (!ok) expired("completion");
  endtask

  task automatic do_write(input logic [IDW-1:0] id, input logic [AW_W-1:0] addr, input int len, input int base);
    exp_aw.push_back('{id: id, addr: addr, len: 8'(len), size: 3'd4});
    for (int i = 0; i <= len; i++) exp_w.push_back('{data: dword(base + i), last: (i == len)});
    exp_rsp.push_back('{resp: 2'b00, err: 1'b0});
    send_cmd(1'b1, id, addr, 8'(len));
    feed(len + 1, base);
    wait_done();
  endtask

  task automatic do_read(input logic [IDW-1:0] id, input logic [AW_W-1:0] addr, input int len, input int base,
                         input logic [1:0] resp, input logic err);
    int last_at = (r_last_cfg < 0) ? len : r_last_cfg;
    exp_ar.push_back('{id: id, addr: addr, len: 8'(len), size: 3'd4});
    for (int i = 0; i <= len; i++) exp_rd.push_back('{data: dword(base + i), last: (i == last_at)});
    exp_rsp.push_back('{resp: resp, err: err});
    send_cmd(1'b0, id, addr, 8'(len));
    wait_done();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, DW'(cmd_ready), DW'(1));
    chk({tag, "_nasti_valids"}, DW'({nasti_bus.aw_valid, nasti_bus.w_valid, nasti_bus.ar_valid,
                                     nasti_bus.b_ready, nasti_bus.r_ready}), DW'(0));
    chk({tag, "_stream_valids"}, DW'({wd_ready, rd_valid, rsp_valid}), DW'(0));
    chk({tag, "_rsp_fields"}, DW'({rsp_resp, rsp_err}), DW'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
    wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b1; rsp_ready = 1'b1;
    #2;
    chk_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // 4-beat write then read back
    do_write(1'b1, 16'h0100, 3, 0);
    $display("write id=1 addr=0x100 len=3 done");
    do_read(1'b0, 16'h0100, 3, 0, 2'b00, 1'b0);
    $display("read addr=0x100 len=3 done");

    // AW held off for 5 cycles while write data is already offered
    aw_stall = 5;
    do_write(1'b0, 16'h0200, 1, 4);
    aw_stall = 0;
    $display("write with aw stall addr=0x200 len=1 done");

    // SLVERR on beat 1
    r_err_cfg = 1;
    do_read(1'b1, 16'h0100, 3, 0, 2'b10, 1'b0);
    r_err_cfg = -1;
    $display("read with SLVERR on beat 1 done");

    // early r_last on beat 2 of len=3
    r_last_cfg = 2;
    do_read(1'b0, 16'h0100, 3, 0, 2'b00, 1'b1);
    r_last_cfg = -1;
    $display("read with early r_last done");

    do_read(1'b0, 16'h0200, 0, 4, 2'b00, 1'b0);
    $display("single-beat read addr=0x200 done");

    // reset while waiting for W beat 2
    exp_aw.push_back('{id: 1'b1, addr: 16'h0300, len: 8'd3, size: 3'd4});
    exp_w.push_back('{data: dword(7), last: 1'b0});
    exp_w.push_back('{data: dword(8), last: 1'b0});
    send_cmd(1'b1, 1'b1, 16'h0300, 8'd3);
    feed(2, 7);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    $display("reset during W beat 2 done");

    do_write(1'b1, 16'h0300, 0, 6);
    $display("single-beat write after reset done");
    do_read(1'b1, 16'h0300, 0, 6, 2'b00, 1'b0);
    $display("single-beat read addr=0x300 done");

    repeat (5) @(posedge clk);
    chk("aw_left", DW'(exp_aw.size()), DW'(0));
    chk("ar_left", DW'(exp_ar.size()), DW'(0));
    chk("w_left", DW'(exp_w.size()), DW'(0));
    chk("rd_left", DW'(exp_rd.size()), DW'(0));
    chk("rsp_left", DW'(exp_rsp.size()), DW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
